// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte-stream requesters, the arbiter and the TX FIFO write side.
interface uart_tx_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_last;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_last;
   logic       req1_ready;
   logic       fifo_we;
   logic [7:0] fifo_data;
   logic       fifo_full;

   // master: requesters plus FIFO, slave: the arbiter
   modport master (
      output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
      input  req0_ready, req1_ready, fifo_we, fifo_data
   );
   modport slave (
      input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
      output req0_ready, req1_ready, fifo_we, fifo_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX FIFO between two requesters,
// prefixing each packet with a source header and splitting packets longer than MAX_LEN.
//
// state   | meaning
// IDLE    | no owner; both VALIDs sampled, winner registered into grant
// HDR     | header byte for the granted source written when FIFO not full
// PAYLOAD | granted requester's bytes forwarded until LAST or MAX_LEN bytes
module uart_tx_arbiter #(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] HDR0    = 8'hA0,
   parameter logic [7:0] HDR1    = 8'hA1
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   uart_tx_arbiter_if.slave   bus,
   output logic [1:0]         GRANT_O,
   output logic               BUSY_O,
   output logic               TRUNC_O
);
   localparam int              CW       = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0]   LAST_CNT = CW'(MAX_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_grant, w_grant_nxt;
   logic          r_ptr;
   logic [CW-1:0] r_count;
   logic          r_trunc;

   logic          w_sel_valid, w_sel_last;
   logic [7:0]    w_sel_data;
   logic          w_we, w_rdy0, w_rdy1, w_accept, w_eop;
   logic [7:0]    w_data;

   assign w_sel_valid = r_grant[1] ? bus.req1_valid : bus.req0_valid;
   assign w_sel_data  = r_grant[1] ? bus.req1_data  : bus.req0_data;
   assign w_sel_last  = r_grant[1] ? bus.req1_last  : bus.req0_last;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_we        = 1'b0;
      w_data      = 8'h00;
      w_rdy0      = 1'b0;
      w_rdy1      = 1'b0;
      w_accept    = 1'b0;
      w_eop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               w_state_nxt = ST_HDR;
               if (bus.req0_valid && bus.req1_valid)
                  w_grant_nxt = r_ptr ? 2'b10 : 2'b01;
               else
                  w_grant_nxt = bus.req0_valid ? 2'b01 : 2'b10;
            end
         end
         ST_HDR: begin
            if (!bus.fifo_full) begin
               w_we        = 1'b1;
               w_data      = r_grant[1] ? HDR1 : HDR0;
               w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            w_rdy0   = r_grant[0] & ~bus.fifo_full;
            w_rdy1   = r_grant[1] & ~bus.fifo_full;
            w_accept = w_sel_valid & ~bus.fifo_full;
            w_we     = w_accept;
            w_data   = w_sel_data;
            w_eop    = w_accept & (w_sel_last | (r_count == LAST_CNT));
            if (w_eop) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = 2'b00;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
         end
      endcase
   end

   // Reset blocks writes in the very cycle it is asserted, so an abandoned packet stops at once.
   assign bus.fifo_we    = w_we & ~RST_I;
   assign bus.fifo_data  = w_data;
   assign bus.req0_ready = w_rdy0 & ~RST_I;
   assign bus.req1_ready = w_rdy1 & ~RST_I;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state <= ST_IDLE;
         r_grant <= 2'b00;
         r_ptr   <= 1'b0;
         r_count <= '0;
         r_trunc <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_trunc <= w_eop & ~w_sel_last;
         if (w_eop) begin
            r_count <= '0;
            r_ptr   <= r_grant[0];
         end else if (w_accept) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign GRANT_O = r_grant;
   assign BUSY_O  = (r_state != ST_IDLE);
   assign TRUNC_O = r_trunc;
endmodule
